// File: rtl/ssm2603_slave_pkg.sv
// Shared types and constants for the SSM2603 I2S slave port.
package ssm2603_pkg;

  typedef enum logic {
    CH_RIGHT = 1'b0,
    CH_LEFT  = 1'b1
  } ch_t;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int SLOT_BCLKS         = 32;

  // Bit counters saturate at SLOT_BCLKS-1, so this width covers a whole slot.
  localparam int                CNT_W   = $clog2(SLOT_BCLKS);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

endpackage

// File: rtl/ssm2603_slave_if.sv
// FIFO-side bundle of the SSM2603 slave: captured words out, playback words in.
interface ssm2603_slave_if
  import ssm2603_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] RECDATLEFT;
  logic [DATA_WIDTH-1:0] RECDATRIGHT;
  logic                  FIFO_REQ_WRITE_LEFT;
  logic                  FIFO_REQ_WRITE_RIGHT;
  logic [DATA_WIDTH-1:0] PBDATLEFT;
  logic [DATA_WIDTH-1:0] PBDATRIGHT;
  logic                  FIFO_REQ_READ_LEFT;
  logic                  FIFO_REQ_READ_RIGHT;

  modport slave (
    output RECDATLEFT, RECDATRIGHT, FIFO_REQ_WRITE_LEFT, FIFO_REQ_WRITE_RIGHT,
    output FIFO_REQ_READ_LEFT, FIFO_REQ_READ_RIGHT,
    input  PBDATLEFT, PBDATRIGHT
  );

  modport master (
    input  RECDATLEFT, RECDATRIGHT, FIFO_REQ_WRITE_LEFT, FIFO_REQ_WRITE_RIGHT,
    input  FIFO_REQ_READ_LEFT, FIFO_REQ_READ_RIGHT,
    output PBDATLEFT, PBDATRIGHT
  );

endinterface

// File: rtl/ssm2603_slave_sync_edge.sv
// Multi-flop synchroniser for one asynchronous codec pin with rise/fall pulses.
module i2s_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic [SYNC_STAGES:0]   fill;
  logic                   prev;

  // fill tracks when chain and prev hold real pin samples, so the pin level
  // at reset release is never mistaken for an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      fill  <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_in};
      fill  <= {fill[SYNC_STAGES-1:0], 1'b1};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = fill[SYNC_STAGES] & level & ~prev;
  assign fall  = fill[SYNC_STAGES] & ~level & prev;

endmodule

// File: rtl/ssm2603_slave.sv
// I2S slave port for the SSM2603 in codec-master mode: deserialises RECDAT and
// serialises FIFO words onto PBDAT, timed from oversampled codec clocks.
module ssm2603_slave
  import ssm2603_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           BCLK,
  input  logic           RECLRC,
  input  logic           RECDAT,
  input  logic           PBLRC,
  output logic           PBDAT,
  output logic           SHORT_SLOT,
  ssm2603_slave_if.slave fifo
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);

  logic       bclk_level_unused, bclk_rise, bclk_fall;
  logic       reclrc_s, recdat_s, pblrc_s, pblrc_rise, pblrc_fall;
  logic [1:0] reclrc_edges_unused, recdat_edges_unused;

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk(clk), .reset(reset), .async_in(BCLK),
    .level(bclk_level_unused), .rise(bclk_rise), .fall(bclk_fall)
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_reclrc (
    .clk(clk), .reset(reset), .async_in(RECLRC),
    .level(reclrc_s), .rise(reclrc_edges_unused[1]), .fall(reclrc_edges_unused[0])
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_recdat (
    .clk(clk), .reset(reset), .async_in(RECDAT),
    .level(recdat_s), .rise(recdat_edges_unused[1]), .fall(recdat_edges_unused[0])
  );

  i2s_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pblrc (
    .clk(clk), .reset(reset), .async_in(PBLRC),
    .level(pblrc_s), .rise(pblrc_rise), .fall(pblrc_fall)
  );

  // ---------------- RX ----------------
  logic                  rx_lrc_prev, rx_lrc_prev_n;
  logic                  rx_lrc_valid, rx_lrc_valid_n;
  logic                  rx_locked, rx_locked_n;
  logic                  rx_done, rx_done_n;
  logic                  rx_short_n;
  ch_t                   rx_ch, rx_ch_n;
  logic [CNT_W-1:0]      rx_cnt, rx_cnt_n;
  logic [DATA_WIDTH-1:0] rx_shift, rx_shift_n;

  // The first BCLK rise after reset only records LRC; locking waits for a real change.
  always_comb begin
    rx_lrc_prev_n  = rx_lrc_prev;
    rx_lrc_valid_n = rx_lrc_valid;
    rx_locked_n    = rx_locked;
    rx_ch_n        = rx_ch;
    rx_cnt_n       = rx_cnt;
    rx_shift_n     = rx_shift;
    rx_done_n      = 1'b0;
    rx_short_n     = 1'b0;
    if (bclk_rise) begin
      rx_lrc_prev_n  = reclrc_s;
      rx_lrc_valid_n = 1'b1;
      if (rx_lrc_valid && (reclrc_s != rx_lrc_prev)) begin
        rx_short_n  = rx_locked && (rx_cnt < FULL_CNT);
        rx_locked_n = 1'b1;
        rx_ch_n     = ch_t'(reclrc_s);
        rx_shift_n  = {{(DATA_WIDTH-1){1'b0}}, recdat_s};
        rx_cnt_n    = CNT_W'(1);
      end else if (rx_locked) begin
        rx_shift_n = {rx_shift[DATA_WIDTH-2:0], recdat_s};
        if (rx_cnt != CNT_MAX) begin
          rx_cnt_n = rx_cnt + CNT_W'(1);
        end
        rx_done_n = (rx_cnt == LAST_BIT);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_lrc_prev               <= 1'b0;
      rx_lrc_valid              <= 1'b0;
      rx_locked                 <= 1'b0;
      rx_ch                     <= CH_RIGHT;
      rx_cnt                    <= '0;
      rx_shift                  <= '0;
      rx_done                   <= 1'b0;
      SHORT_SLOT                <= 1'b0;
      fifo.RECDATLEFT           <= '0;
      fifo.RECDATRIGHT          <= '0;
      fifo.FIFO_REQ_WRITE_LEFT  <= 1'b0;
      fifo.FIFO_REQ_WRITE_RIGHT <= 1'b0;
    end else begin
      rx_lrc_prev               <= rx_lrc_prev_n;
      rx_lrc_valid              <= rx_lrc_valid_n;
      rx_locked                 <= rx_locked_n;
      rx_ch                     <= rx_ch_n;
      rx_cnt                    <= rx_cnt_n;
      rx_shift                  <= rx_shift_n;
      rx_done                   <= rx_done_n;
      SHORT_SLOT                <= rx_short_n;
      fifo.FIFO_REQ_WRITE_LEFT  <= rx_done && (rx_ch == CH_LEFT);
      fifo.FIFO_REQ_WRITE_RIGHT <= rx_done && (rx_ch == CH_RIGHT);
      if (rx_done && (rx_ch == CH_LEFT)) begin
        fifo.RECDATLEFT <= rx_shift;
      end
      if (rx_done && (rx_ch == CH_RIGHT)) begin
        fifo.RECDATRIGHT <= rx_shift;
      end
    end
  end

  // ---------------- TX ----------------
  logic                  tx_locked, tx_locked_n;
  logic                  tx_armed, tx_armed_n;
  logic [CNT_W-1:0]      tx_cnt, tx_cnt_n;
  logic [DATA_WIDTH-1:0] tx_shift, tx_shift_n;

  assign fifo.FIFO_REQ_READ_LEFT  = pblrc_rise;
  assign fifo.FIFO_REQ_READ_RIGHT = pblrc_fall;
  assign PBDAT                    = tx_shift[DATA_WIDTH-1];

  // A fall only shifts once a rise has been seen since the load, so the MSB
  // survives whichever of LRC or BCLK reaches the synchronisers first.
  always_comb begin
    tx_locked_n = tx_locked;
    tx_armed_n  = tx_armed;
    tx_cnt_n    = tx_cnt;
    tx_shift_n  = tx_shift;
    if (pblrc_rise || pblrc_fall) begin
      tx_shift_n  = pblrc_s ? fifo.PBDATLEFT : fifo.PBDATRIGHT;
      tx_locked_n = 1'b1;
      tx_armed_n  = 1'b0;
      tx_cnt_n    = '0;
    end else begin
      if (bclk_rise && tx_locked) begin
        tx_armed_n = 1'b1;
      end
      if (bclk_fall && tx_armed) begin
        tx_shift_n = {tx_shift[DATA_WIDTH-2:0], 1'b0};
        if (tx_cnt != CNT_MAX) begin
          tx_cnt_n = tx_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_locked <= 1'b0;
      tx_armed  <= 1'b0;
      tx_cnt    <= '0;
      tx_shift  <= '0;
    end else begin
      tx_locked <= tx_locked_n;
      tx_armed  <= tx_armed_n;
      tx_cnt    <= tx_cnt_n;
      tx_shift  <= tx_shift_n;
    end
  end

endmodule

// File: tb/tb_ssm2603_slave.sv
// Codec BFM bench for ssm2603_slave: 32x oversampled BCLK, 64-BCLK frames,
// table-driven frames plus reset, short-slot, skew and loopback sequences.
module tb_ssm2603_slave;
  import ssm2603_pkg::*;

  localparam int HALF = 16;

  typedef struct packed {
    logic        ch;
    logic [15:0] word;
  } rx_exp_t;

  typedef struct {
    logic [15:0] rec_left;
    logic [15:0] rec_right;
    logic [15:0] pb_left;
    logic [15:0] pb_right;
    int          skew;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
  } vec_t;

  logic clk = 1'b0;
  logic reset, bclk, reclrc, recdat_bfm, pblrc, loopback;
  logic pbdat, short_slot, recdat_pin;

  int checks = 0;
  int failures = 0;
  int exp_reads_left = 0, exp_reads_right = 0, exp_shorts = 0;
  int reads_left = 0, reads_right = 0, shorts = 0;
  int obs_n = 0, obs_rd = 0;
  logic [15:0] obs_word [0:511];
  logic        obs_ch   [0:511];
  rx_exp_t     rx_q[$];
  vec_t        vecs[5];

  assign recdat_pin = loopback ? pbdat : recdat_bfm;

  ssm2603_slave_if fifo ();

  ssm2603_slave #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .BCLK(bclk), .RECLRC(reclrc), .RECDAT(recdat_pin),
    .PBLRC(pblrc), .PBDAT(pbdat), .SHORT_SLOT(short_slot), .fifo(fifo)
  );

  always #5 clk = ~clk;

  // Records every DUT write and counts read/short pulses for the main process.
  always @(negedge clk) begin
    if (fifo.FIFO_REQ_WRITE_LEFT === 1'b1 || fifo.FIFO_REQ_WRITE_RIGHT === 1'b1) begin
      if (obs_n < 512) begin
        obs_ch[obs_n]   = fifo.FIFO_REQ_WRITE_LEFT;
        obs_word[obs_n] = fifo.FIFO_REQ_WRITE_LEFT ? fifo.RECDATLEFT : fifo.RECDATRIGHT;
      end
      obs_n++;
    end
    if (fifo.FIFO_REQ_READ_LEFT === 1'b1)  reads_left++;
    if (fifo.FIFO_REQ_READ_RIGHT === 1'b1) reads_right++;
    if (short_slot === 1'b1)               shorts++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded time budget checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  // One channel slot of nbits BCLKs; LRC moves skew clk after (+) or before (-) the first fall.
  task automatic runSlot(input logic lrc, input logic [15:0] rx_word, input int nbits,
                         input int skew, output logic [31:0] tx_bits);
    int rem;
    tx_bits = '0;
    for (int b = 0; b < nbits; b++) begin
      rem = HALF;
      if (b == 0 && skew < 0) begin
        reclrc = lrc; pblrc = lrc;
        waitClk(-skew);
      end
      bclk = 1'b0;
      recdat_bfm = (b < 16) ? rx_word[15-b] : 1'b0;
      if (b == 0 && skew > 0) begin
        waitClk(skew);
        rem = HALF - skew;
      end
      if (b == 0 && skew >= 0) begin
        reclrc = lrc; pblrc = lrc;
      end
      waitClk(rem);
      bclk = 1'b1;
      tx_bits = {tx_bits[30:0], pbdat};
      waitClk(HALF);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    logic [31:0] txb;
    rx_exp_t e;
    fifo.PBDATLEFT  = v.pb_left;
    fifo.PBDATRIGHT = v.pb_right;
    e.ch = 1'b1; e.word = loopback ? v.pb_left : v.rec_left;
    rx_q.push_back(e);
    exp_reads_left++;
    runSlot(1'b1, v.rec_left, 32, v.skew, txb);
    checkVal({tag, " tx_left"}, txb, {v.pb_left, 16'h0000});
    e.ch = 1'b0; e.word = loopback ? v.pb_right : v.rec_right;
    rx_q.push_back(e);
    exp_reads_right++;
    runSlot(1'b0, v.rec_right, 32, v.skew, txb);
    checkVal({tag, " tx_right"}, txb, {v.pb_right, 16'h0000});
  endtask

  task automatic checkOutput(input string tag);
    rx_exp_t e;
    while (obs_rd < obs_n) begin
      if (rx_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL %s unexpected_write: got ch=%0d word=%h expected none",
                 tag, obs_ch[obs_rd], obs_word[obs_rd]);
      end else begin
        e = rx_q.pop_front();
        checkVal({tag, " rx_word"}, {15'h0, obs_ch[obs_rd], obs_word[obs_rd]},
                 {15'h0, e.ch, e.word});
      end
      obs_rd++;
    end
    checkVal({tag, " rx_missing"}, rx_q.size(), 0);
    checkVal({tag, " reads_left"}, reads_left, exp_reads_left);
    checkVal({tag, " reads_right"}, reads_right, exp_reads_right);
    checkVal({tag, " short_slots"}, shorts, exp_shorts);
  endtask

  initial begin
    logic [31:0] txb;
    rx_exp_t     e;
    vec_t        v;
    int          sk;

    vecs[0] = '{16'hA5C3, 16'h0001, 16'h8001, 16'h7FFE,  0, 16'hA5C3, 16'h0001};
    vecs[1] = '{16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF,  0, 16'hFFFF, 16'h0000};
    vecs[2] = '{16'h8000, 16'h7FFF, 16'h1234, 16'hFEDC,  2, 16'h8000, 16'h7FFF};
    vecs[3] = '{16'h5A5A, 16'hC3C3, 16'hAAAA, 16'h5555, -2, 16'h5A5A, 16'hC3C3};
    vecs[4] = '{16'h0F0F, 16'hF0F0, 16'h8001, 16'h0001,  0, 16'h0F0F, 16'hF0F0};

    reset = 1'b1; bclk = 1'b0; reclrc = 1'b0; pblrc = 1'b0; recdat_bfm = 1'b0;
    loopback = 1'b0; fifo.PBDATLEFT = '0; fifo.PBDATRIGHT = '0;
    waitClk(8);
    checkVal("reset recdat_left", fifo.RECDATLEFT, 0);
    checkVal("reset recdat_right", fifo.RECDATRIGHT, 0);
    checkVal("reset pbdat", pbdat, 0);
    checkVal("reset pulses", {fifo.FIFO_REQ_WRITE_LEFT, fifo.FIFO_REQ_WRITE_RIGHT,
             fifo.FIFO_REQ_READ_LEFT, fifo.FIFO_REQ_READ_RIGHT, short_slot}, 0);
    reset = 1'b0;
    runSlot(1'b0, 16'h0000, 4, 0, txb);
    checkOutput("leadin");

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d", i));
      checkVal($sformatf("vec%0d recdat_left", i), fifo.RECDATLEFT, vecs[i].exp_left);
      checkVal($sformatf("vec%0d recdat_right", i), fifo.RECDATRIGHT, vecs[i].exp_right);
    end

    // Short left slot of 10 BCLKs, then a full right slot and a normal frame.
    fifo.PBDATLEFT = 16'h1111; fifo.PBDATRIGHT = 16'hC001;
    exp_reads_left++;
    runSlot(1'b1, 16'hFFFF, 10, 0, txb);
    e.ch = 1'b0; e.word = 16'h4321;
    rx_q.push_back(e);
    exp_reads_right++;
    exp_shorts++;
    runSlot(1'b0, 16'h4321, 32, 0, txb);
    checkVal("short tx_right", txb, {16'hC001, 16'h0000});
    applyStimulus(vecs[0], "after_short");
    checkOutput("after_short");

    // Reset asserted mid-left slot, released mid-right slot.
    fifo.PBDATLEFT = 16'hDEAD; fifo.PBDATRIGHT = 16'hBEEF;
    exp_reads_left++;
    fork
      begin
        runSlot(1'b1, 16'h1357, 32, 0, txb);
        runSlot(1'b0, 16'h2468, 32, 0, txb);
      end
      begin
        waitClk(10 * 2 * HALF);
        reset = 1'b1;
        waitClk(48 * 2 * HALF - 10 * 2 * HALF);
        reset = 1'b0;
      end
    join
    checkVal("reset_mid tx_right", txb, 0);
    checkVal("reset_mid recdat_left", fifo.RECDATLEFT, 0);
    checkVal("reset_mid recdat_right", fifo.RECDATRIGHT, 0);
    checkVal("reset_mid pbdat", pbdat, 0);
    checkOutput("reset_mid");
    applyStimulus(vecs[4], "after_reset");
    checkOutput("after_reset");
    checkVal("after_reset recdat_left", fifo.RECDATLEFT, 16'h0F0F);

    // Loopback of PBDAT into RECDAT with random words and random LRC skew.
    loopback = 1'b1;
    for (int f = 0; f < 12; f++) begin
      sk = int'($urandom_range(0, 2)) * 2 - 2;
      v = '{16'h0000, 16'h0000, 16'($urandom), 16'($urandom), sk, 16'h0000, 16'h0000};
      applyStimulus(v, $sformatf("loop%0d", f));
      checkOutput($sformatf("loop%0d", f));
      checkVal($sformatf("loop%0d recdat_left", f), fifo.RECDATLEFT, v.pb_left);
    end
    loopback = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
